// File: rtl/uart_rx_os_if.sv
// Receiver-side bus for uart_rx_os: serial line in, parallel byte and status strobes out.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_i;
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 frame_err_o;
    logic                 busy_o;

    modport slave  (input  rx_i, output data_o, output valid_o, output frame_err_o, output busy_o);
    modport master (output rx_i, input  data_o, input  valid_o, input  frame_err_o, input  busy_o);
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 1 start, DATA_BITS data (LSB first), 1 stop, no parity.
// Every bit is sampled at its middle, using the same CLKS_PER_BIT count as the transmitter.
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_os_if.slave  bus
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;
    logic                 w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], bus.rx_i};
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    // A start bit that has gone high again by mid-bit is treated as noise.
                    if (r_cnt == HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_idx == LAST_BIT) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch an immediate next start.
                    if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BRK;
                        end
                    end
                end
                BRK: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_o      = r_data;
    assign bus.valid_o     = r_valid;
    assign bus.frame_err_o = r_ferr;
    assign bus.busy_o      = r_busy;
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: stimulus queues expected strobes, a monitor pops and checks them.
module tb_uart_rx_os;
    localparam int CPB = 16;
    localparam int LAT = 155;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t q[$];

    uart_rx_os_if #(.DATA_BITS(8)) bus ();

    uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.rx_i = b;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit is_err,
                              input logic [7:0] exp_d);
        exp_t e;
        e.err  = is_err;
        e.data = exp_d;
        e.cyc  = cyc + LAT;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    bit prev_strobe = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.valid_o || bus.frame_err_o) begin
                chk("strobe_exclusive", {31'd0, bus.valid_o & bus.frame_err_o}, 32'd0);
                chk("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual valid=%0b err=%0b required none at cyc=%0d",
                             bus.valid_o, bus.frame_err_o, cyc);
                end else begin
                    e = q.pop_front();
                    chk("strobe_kind", {31'd0, bus.frame_err_o}, {31'd0, e.err});
                    chk("strobe_data", {24'd0, bus.data_o}, {24'd0, e.data});
                    checks++;
                    if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                        failures++;
                        $display("FAIL strobe_latency actual_cyc=%0d required_cyc=%0d(+-1)", cyc, e.cyc);
                    end
                end
            end
            prev_strobe = bus.valid_o || bus.frame_err_o;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        logic [7:0] v;
        int guard;
        bus.rx_i = 1'b1;
        rst = 1'b1;
        idle(5);
        rst = 1'b0;
        chk("rst_data", {24'd0, bus.data_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_ferr", {31'd0, bus.frame_err_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        idle(200);

        send_frame(8'hA5, 1'b1, 1'b0, 8'hA5);
        idle(20);

        send_frame(8'h00, 1'b1, 1'b0, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
        send_frame(8'h3C, 1'b1, 1'b0, 8'h3C);
        idle(20);

        bus.rx_i = 1'b0;
        idle(4);
        chk("glitch_busy_high", {31'd0, bus.busy_o}, 32'd1);
        bus.rx_i = 1'b1;
        idle(20);
        chk("glitch_busy_low", {31'd0, bus.busy_o}, 32'd0);
        chk("glitch_data_kept", {24'd0, bus.data_o}, 32'h3C);

        send_frame(8'h55, 1'b0, 1'b1, 8'h3C);
        idle(400);
        chk("break_busy", {31'd0, bus.busy_o}, 32'd1);
        bus.rx_i = 1'b1;
        idle(20);
        chk("break_released", {31'd0, bus.busy_o}, 32'd0);
        chk("break_data_kept", {24'd0, bus.data_o}, 32'h3C);
        send_frame(8'h81, 1'b1, 1'b0, 8'h81);
        idle(20);

        v = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v[i]);
        bus.rx_i = v[4];
        idle(8);
        rst = 1'b1;
        idle(3);
        bus.rx_i = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("midrst_data", {24'd0, bus.data_o}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
        idle(40);
        chk("midrst_no_start", {31'd0, bus.busy_o}, 32'd0);
        send_frame(8'h12, 1'b1, 1'b0, 8'h12);

        guard = 0;
        while (q.size() != 0 && guard < 400) begin
            idle(1);
            guard++;
        end
        idle(20);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
